// File: rtl/enc_pkg.sv
// Shared types and constants for the result encoder: FSM state encoding, ASCII codes,
// digit/width constants, and helpers that pick digits out of the packed BCD register.
// Imported by result_encoder and bin2bcd_seq.
package enc_pkg;

    localparam int W    = 32;        // binary result width
    localparam int NDIG = 10;        // decimal digits needed for 2^32-1
    localparam int BCDW = 4 * NDIG;  // packed BCD width

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        CONV,
        SEND_SIGN,
        SEND_DIG,
        SEND_CR,
        SEND_LF
    } state_t;

    // Index of the most significant nonzero digit; 0 when the value is zero, so a
    // lone '0' is still printed.
    function automatic logic [3:0] first_nonzero(input logic [BCDW-1:0] bcd);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] != 4'd0) r = 4'(i);
        end
        return r;
    endfunction

    // ASCII character for BCD digit idx.
    function automatic logic [7:0] digit_char(input logic [BCDW-1:0] bcd,
                                              input logic [3:0]      idx);
        logic [BCDW-1:0] sh;
        sh = bcd >> {idx, 2'b00};
        return CH_ZERO + {4'd0, sh[3:0]};
    endfunction

endpackage

// File: rtl/result_encoder_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble), one shift step per clock.
// Ports: start loads bin and clears the BCD register; done is high once all 32 steps are
// complete and stays high, with bcd stable, until the next start.
module bin2bcd_seq
    import enc_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            done,
    output logic [BCDW-1:0] bcd
);

    logic [W-1:0]    bin_q;
    logic [BCDW-1:0] bcd_q;
    logic [BCDW-1:0] adj;
    logic [5:0]      cnt_q;
    logic            run_q;

    // Add 3 to every nibble >= 5 so the following shift carries correctly into
    // the next decimal digit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q && (cnt_q != 6'(W))) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            cnt_q          <= cnt_q + 6'd1;
        end
    end

    assign done = run_q && (cnt_q == 6'(W));
    assign bcd  = bcd_q;

endmodule

// File: rtl/result_encoder.sv
// Captures an ALU result on alu_done and streams it to the UART as decimal ASCII
// (optional '-', digits without leading zeros, optional CR/LF) over valid/ready.
// Ports: alu_done/calc_res in; tx_data/uout_valid out with tx_ready back; busy and drop status.
module result_encoder
    import enc_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b1,
    parameter bit APPEND_CR   = 1'b1,
    parameter bit APPEND_LF   = 1'b1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         alu_done,
    input  logic [W-1:0] calc_res,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         uout_valid,
    output logic         busy,
    output logic         drop
);

    state_t          state_q;
    logic [W-1:0]    res_q;
    logic            neg_q;
    logic [3:0]      idx_q;
    logic [7:0]      tx_data_q;
    logic            valid_q;
    logic            busy_q;
    logic            drop_q;

    logic            is_neg;
    logic [W-1:0]    mag;
    logic            conv_start;
    logic            conv_done;
    logic [BCDW-1:0] bcd;

    // Two's-complement magnitude; 0x80000000 maps to 2^31, which fits unsigned.
    assign is_neg     = SIGNED_MODE && res_q[W-1];
    assign mag        = is_neg ? (~res_q + 32'd1) : res_q;
    assign conv_start = (state_q == ABS);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .n_rst (n_rst),
        .start (conv_start),
        .bin   (mag),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            res_q     <= '0;
            neg_q     <= 1'b0;
            idx_q     <= '0;
            tx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            // A result arriving while a string is in flight is discarded.
            drop_q <= alu_done && busy_q;
            case (state_q)
                IDLE: begin
                    if (alu_done) begin
                        res_q   <= calc_res;
                        busy_q  <= 1'b1;
                        state_q <= ABS;
                    end
                end
                ABS: begin
                    neg_q   <= is_neg;
                    state_q <= CONV;
                end
                CONV: begin
                    if (conv_done) begin
                        idx_q   <= first_nonzero(bcd);
                        valid_q <= 1'b1;
                        if (neg_q) begin
                            tx_data_q <= CH_MINUS;
                            state_q   <= SEND_SIGN;
                        end else begin
                            tx_data_q <= digit_char(bcd, first_nonzero(bcd));
                            state_q   <= SEND_DIG;
                        end
                    end
                end
                SEND_SIGN: begin
                    if (tx_ready) begin
                        tx_data_q <= digit_char(bcd, idx_q);
                        state_q   <= SEND_DIG;
                    end
                end
                SEND_DIG: begin
                    if (tx_ready) begin
                        if (idx_q != 4'd0) begin
                            idx_q     <= idx_q - 4'd1;
                            tx_data_q <= digit_char(bcd, idx_q - 4'd1);
                        end else if (APPEND_CR) begin
                            tx_data_q <= CH_CR;
                            state_q   <= SEND_CR;
                        end else if (APPEND_LF) begin
                            tx_data_q <= CH_LF;
                            state_q   <= SEND_LF;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                SEND_CR: begin
                    if (tx_ready) begin
                        if (APPEND_LF) begin
                            tx_data_q <= CH_LF;
                            state_q   <= SEND_LF;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                SEND_LF: begin
                    if (tx_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign uout_valid = valid_q;
    assign busy       = busy_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_result_encoder.sv
module tb_result_encoder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        alu_done_s, alu_done_u;
    logic [31:0] calc_res;
    logic        tx_ready;
    logic [7:0]  tx_data_s, tx_data_u;
    logic        valid_s, valid_u;
    logic        busy_s, busy_u;
    logic        drop_s, drop_u;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_s = 0;
    int last_u = 0;
    byte qs[$];
    byte qu[$];
    bit   stall_s = 1'b0;
    logic [7:0] prev_s = 8'h00;
    int  rdy_mode = 0;
    bit  did_hold = 1'b0;
    int  hold = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signed instance with CR/LF; unsigned instance with no terminators.
    result_encoder dut_s (
        .clk(clk), .n_rst(n_rst), .alu_done(alu_done_s), .calc_res(calc_res),
        .tx_ready(tx_ready), .tx_data(tx_data_s), .uout_valid(valid_s),
        .busy(busy_s), .drop(drop_s)
    );

    result_encoder #(.SIGNED_MODE(1'b0), .APPEND_CR(1'b0), .APPEND_LF(1'b0)) dut_u (
        .clk(clk), .n_rst(n_rst), .alu_done(alu_done_u), .calc_res(calc_res),
        .tx_ready(tx_ready), .tx_data(tx_data_u), .uout_valid(valid_u),
        .busy(busy_u), .drop(drop_u)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfer monitor and hold-stable check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!n_rst) begin
            stall_s = 1'b0;
        end else begin
            if (stall_s) begin
                check("hold_valid", valid_s, 1'b1);
                check("hold_data", tx_data_s, prev_s);
            end
            if (valid_s && tx_ready) begin
                qs.push_back(tx_data_s);
                last_s = cyc;
            end
            if (valid_u && tx_ready) begin
                qu.push_back(tx_data_u);
                last_u = cyc;
            end
            stall_s = valid_s && !tx_ready;
            prev_s  = tx_data_s;
        end
    end

    // tx_ready driver: 0 = always ready, 1 = random with a 20-cycle hold-off, 2 = never.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                tx_ready = 1'b1;
            end else if (rdy_mode == 2) begin
                tx_ready = 1'b0;
            end else if (hold > 0) begin
                tx_ready = 1'b0;
                hold--;
            end else if (qs.size() == 1 && !did_hold) begin
                did_hold = 1'b1;
                hold     = 19;
                tx_ready = 1'b0;
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [31:0] v, input bit sel_u);
        calc_res = v;
        if (sel_u) alu_done_u = 1'b1;
        else       alu_done_s = 1'b1;
        @(posedge clk);
        #1;
        alu_done_s = 1'b0;
        alu_done_u = 1'b0;
    endtask

    task automatic collect(input bit sel_u, input string exp, input string tag);
        int n;
        byte q[$];
        logic [7:0] b;
        n = 0;
        while ((sel_u ? busy_u : busy_s) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " busy_clear"}, sel_u ? busy_u : busy_s, 1'b0);
        check({tag, " busy_fall_cycle"}, cyc, (sel_u ? last_u : last_s) + 1);
        if (sel_u) q = qu;
        else       q = qs;
        check({tag, " length"}, q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            b = (i < q.size()) ? q[i] : 8'hxx;
            check($sformatf("%s byte%0d", tag, i), b, exp[i]);
        end
    endtask

    task automatic run(input logic [31:0] v, input bit sel_u, input string exp, input string tag);
        int lat;
        if (sel_u) qu.delete();
        else       qs.delete();
        pulse(v, sel_u);
        lat = 0;
        while (!(sel_u ? valid_u : valid_s) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, 34);
        collect(sel_u, exp, tag);
    endtask

    initial begin
        int n;
        n_rst      = 1'b0;
        alu_done_s = 1'b0;
        alu_done_u = 1'b0;
        calc_res   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst tx_data", tx_data_s, 8'h00);
        check("rst valid", valid_s, 1'b0);
        check("rst busy", busy_s, 1'b0);
        check("rst drop", drop_s, 1'b0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        run(32'd0,          1'b0, "0\015\012",           "zero");
        run(32'd12345,      1'b0, "12345\015\012",       "12345");
        run(32'hFFFFFFFF,   1'b0, "-1\015\012",          "minus1");
        run(32'h80000000,   1'b0, "-2147483648\015\012", "intmin");
        run(32'hFFFFFFFF,   1'b1, "4294967295",          "uns_max");
        run(32'd0,          1'b1, "0",                   "uns_zero");

        // Random backpressure with a long stall in the middle of the string.
        rdy_mode = 1;
        did_hold = 1'b0;
        run(32'd7, 1'b0, "7\015\012", "stall7");
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Second result 5 cycles after the first is dropped.
        qs.delete();
        pulse(32'd42, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        calc_res   = 32'd99;
        alu_done_s = 1'b1;
        @(posedge clk);
        #1;
        alu_done_s = 1'b0;
        check("drop pulse", drop_s, 1'b1);
        @(posedge clk);
        #1;
        check("drop single", drop_s, 1'b0);
        collect(1'b0, "42\015\012", "drop_first");
        repeat (60) @(posedge clk);
        #1;
        check("drop no_second_string", qs.size(), 4);
        check("drop idle_valid", valid_s, 1'b0);

        // Reset while stalled in the digit phase.
        rdy_mode = 2;
        qs.delete();
        pulse(32'd12345, 1'b0);
        n = 0;
        while (!valid_s && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_rst reached_send", valid_s, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("mid_rst valid", valid_s, 1'b0);
        check("mid_rst busy", busy_s, 1'b0);
        @(posedge clk);
        #1;
        n_rst    = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("mid_rst no_bytes", qs.size(), 0);
        run(32'd5, 1'b0, "5\015\012", "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
